// File: rtl/neg_arb_pkg.sv
// neg_arb_pkg: shared defaults and sizing helpers for the negator arbiter
package neg_arb_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int NREQ_DEFAULT  = 4;

    // Most-negative two's-complement value of the given width, in the low bits
    function automatic logic [63:0] min_signed(input int width);
        return 64'd1 << (width - 1);
    endfunction

    // Bits needed to name one of nreq requesters (never less than one)
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/signed_negator_core.sv
// signed_negator_core: combinational two's-complement negation with min-value flag
module signed_negator_core
    import neg_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_in0,
    output logic [WIDTH-1:0] o_out,
    output logic             o_ovf
);

    localparam logic [WIDTH-1:0] L_MIN = WIDTH'(min_signed(WIDTH));

    // The most-negative value negates to itself; flag it so callers can tell
    assign o_out = ~i_in0 + WIDTH'(1);
    assign o_ovf = (i_in0 == L_MIN);

endmodule

// File: rtl/negator_arbiter.sv
// negator_arbiter: round-robin sharing of one negator with a single-entry result register
module negator_arbiter
    import neg_arb_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEFAULT,
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_ovf,
    input  logic                  rsp_ready
);

    logic [IDW-1:0]   r_ptr;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [IDW-1:0]   r_id;
    logic             r_ovf;

    logic             w_found;
    logic             w_can;
    logic             w_grant;
    logic [IDW-1:0]   w_id;
    logic [IDW-1:0]   w_nptr;
    logic [WIDTH-1:0] w_opnd;
    logic [WIDTH-1:0] w_neg;
    logic             w_ovf;

    // First valid requester at or after ptr, wrapping; MSB of the result says one was found
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid, input logic [IDW-1:0] ptr);
        logic [IDW:0] pick;
        int           idx;
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx -= NREQ;
            if (valid[idx]) pick = {1'b1, IDW'(idx)};
        end
        return pick;
    endfunction

    assign {w_found, w_id} = rr_pick(req_valid, r_ptr);
    assign w_can     = !r_valid || rsp_ready;
    assign w_grant   = rst_n && w_found && w_can;
    assign req_ready = w_grant ? NREQ'(1) << w_id : '0;
    assign w_opnd    = req_data[w_id*WIDTH +: WIDTH];
    assign w_nptr    = (w_id == IDW'(NREQ - 1)) ? '0 : w_id + 1'b1;

    signed_negator_core #(.WIDTH(WIDTH)) u_core (
        .i_in0 (w_opnd),
        .o_out (w_neg),
        .o_ovf (w_ovf)
    );

    // Load on a grant, empty on a drain with no grant, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_ovf   <= 1'b0;
        end else if (w_grant) begin
            r_ptr   <= w_nptr;
            r_valid <= 1'b1;
            r_data  <= w_neg;
            r_id    <= w_id;
            r_ovf   <= w_ovf;
        end else if (rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;
    assign rsp_ovf   = r_ovf;

endmodule

// File: tb/tb_negator_arbiter.sv
// tb_negator_arbiter: scoreboard bench with a round-robin reference model
module tb_negator_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    typedef struct {
        int id;
        int data;
        int ovf;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic [1:0]            rsp_id;
    logic                  rsp_ovf;
    logic                  rsp_ready;

    int checks   = 0;
    int failures = 0;

    exp_t            q[$];
    exp_t            m_e;
    int              m_ptr;
    bit              m_full;
    int              m_win;
    int              m_op;
    logic [NREQ-1:0] m_rdy;
    logic [NREQ-1:0] m_acc;

    negator_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: grant = first valid requester scanning up from ptr modulo NREQ
    always begin
        @(posedge clk);
        #3;
        if (!rst_n) begin
            m_ptr  = 0;
            m_full = 0;
            m_acc  = '0;
            q.delete();
        end else begin
            m_win = -1;
            for (int k = 0; k < NREQ; k++)
                if (m_win < 0 && req_valid[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
            m_rdy = '0;
            if (m_win >= 0 && (!m_full || rsp_ready)) m_rdy[m_win] = 1'b1;
            chk("req_ready", int'(req_ready), int'(m_rdy));
            chk("rsp_valid", int'(rsp_valid), int'(m_full));
            if (m_full && rsp_ready) m_full = 0;
            m_acc = m_rdy;
            if (m_rdy != '0) begin
                m_op   = int'(req_data[m_win*WIDTH +: WIDTH]);
                m_e.id   = m_win;
                m_e.data = ((1 << WIDTH) - m_op) % (1 << WIDTH);
                m_e.ovf  = (m_op == (1 << (WIDTH - 1))) ? 1 : 0;
                q.push_back(m_e);
                m_full = 1;
                m_ptr  = (m_win + 1) % NREQ;
            end
        end
    end

    // Monitor: every presented result is compared with the oldest expectation
    always begin
        @(posedge clk);
        #3;
        if (rst_n && rsp_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_data", int'(rsp_data), q[0].data);
                chk("rsp_id", int'(rsp_id), q[0].id);
                chk("rsp_ovf", int'(rsp_ovf), q[0].ovf);
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [WIDTH-1:0] d);
        req_valid[i] = 1'b1;
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic chk_rsp(input string n, input int d, input int id, input int ovf);
        #1;
        chk({n, "_valid"}, int'(rsp_valid), 1);
        chk({n, "_data"}, int'(rsp_data), d);
        chk({n, "_id"}, int'(rsp_id), id);
        chk({n, "_ovf"}, int'(rsp_ovf), ovf);
    endtask

    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            3:       return 8'hFF;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tick();
        tick();
        #1;
        chk("reset_valid", int'(rsp_valid), 0);
        chk("reset_data", int'(rsp_data), 0);
        chk("reset_id", int'(rsp_id), 0);
        chk("reset_ovf", int'(rsp_ovf), 0);
        tick();
        rst_n = 1'b1;

        put(0, 8'h01);
        tick();
        req_valid = '0;
        chk_rsp("t1", 8'hFF, 0, 0);

        put(2, 8'h05);
        tick();
        put(2, 8'hFF);
        chk_rsp("t2a", 8'hFB, 2, 0);
        tick();
        put(2, 8'h00);
        chk_rsp("t2b", 8'h01, 2, 0);
        tick();
        req_valid = '0;
        chk_rsp("t2c", 8'h00, 2, 0);

        put(1, 8'h80);
        tick();
        put(1, 8'h7F);
        chk_rsp("t3a", 8'h80, 1, 1);
        tick();
        req_valid = '0;
        chk_rsp("t3b", 8'h81, 1, 0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) put(i, WIDTH'(i + 1));
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_rsp("t4", 255 - (k % 4), k % 4, 0);
        end

        req_valid = '0;
        put(0, 8'h05);
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        put(3, 8'h10);
        for (int k = 0; k < 3; k++) begin
            chk_rsp("t5_hold", 8'hFB, 0, 0);
            chk("t5_blocked", int'(req_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t5_release", int'(req_ready), 8);
        tick();
        req_valid = '0;
        chk_rsp("t5_acc", 8'hF0, 3, 0);

        put(2, 8'h33);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", int'(rsp_valid), 0);
        chk("t6_reset_ready", int'(req_ready), 0);
        tick();
        rst_n     = 1'b1;
        req_valid = '0;
        put(1, 8'h11);
        put(3, 8'h22);
        #1;
        chk("t6_grant", int'(req_ready), 2);
        tick();
        req_valid = '0;
        chk_rsp("t6", 8'hEF, 1, 0);

        for (int c = 0; c < 2000; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !m_acc[i]) begin
                    if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    req_data[i*WIDTH +: WIDTH] = rnd_op();
                end
            end
            tick();
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        chk("drain_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
